// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and address helper for the SRAM frame arbiter
//
// Purpose: slot and phase types for the 4-slot SRAM access rotation, plus the
// frame-buffer address builder {frame, y, x}.
// Ports: none (package).
package sram_arb_pkg;

  typedef enum logic [1:0] {
    S_WR0 = 2'd0,
    S_VGA = 2'd1,
    S_WR1 = 2'd2,
    S_BG  = 2'd3
  } slot_e;

  typedef logic phase_t;

  // Widths are passed in because package functions cannot see module
  // parameters; callers cast the 32-bit result down to their ADDR_W.
  // Coordinates are masked to their field widths, so out-of-range values alias.
  function automatic logic [31:0] make_addr(input logic frame, input logic [31:0] x,
                                            input logic [31:0] y, input int x_w, input int y_w);
    logic [31:0] xm;
    logic [31:0] ym;
    xm = x & ((32'd1 << x_w) - 32'd1);
    ym = y & ((32'd1 << y_w) - 32'd1);
    return ({31'd0, frame} << (x_w + y_w)) | (ym << x_w) | xm;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered priority pointer
//
// Purpose: picks the first requester at or after the pointer; on advance with
// a grant, the pointer moves to the channel after the winner.
// Ports:
//   sram_clk  in   clock
//   reset_n   in   asynchronous active-low reset (pointer -> 0)
//   req       in   N request lines
//   advance   in   arbitration cycle; pointer updates only when asserted
//   gnt       out  N one-hot grant (combinational, all zero when no request)
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         sram_clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             found;
  int               idx;
  int               sel;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        sel      = idx;
      end
    end
    ptr_nxt = PTR_W'((sel + 1) % N);
  end

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/sram_frame_arbiter.sv
// rtl/sram_frame_arbiter.sv - double-buffered SRAM frame-buffer controller
//
// Purpose: time-shares one async SRAM between N_WR write channels, the VGA
// scan-out read and the background clear using a fixed 8-cycle rotation
// (S_WR0, S_VGA, S_WR1, S_BG; 2 cycles each), and swaps display/hidden
// frames on frame_clk at the rotation boundary.
// Ports:
//   sram_clk, reset_n            clock, asynchronous active-low reset
//   frame_clk                    frame tick level (synchronised here)
//   wr_valid/wr_ready            per-channel request / one-hot grant pulse
//   wr_x, wr_y, wr_data, wr_be   packed per-channel write fields
//   bg_data, bg_en               background clear pixel and enable
//   vga_x, vga_y                 scan position
//   vga_data, vga_data_valid     read pixel and its 1-cycle strobe
//   display_frame, frame_swapped current display frame and swap pulse
//   SRAM_*                       registered SRAM controls, address, data bus
module sram_frame_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_WR   = 2,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
) (
  input  logic                   sram_clk,
  input  logic                   reset_n,
  input  logic                   frame_clk,
  input  logic [N_WR-1:0]        wr_valid,
  output logic [N_WR-1:0]        wr_ready,
  input  logic [N_WR*X_W-1:0]    wr_x,
  input  logic [N_WR*Y_W-1:0]    wr_y,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  input  logic [N_WR*2-1:0]      wr_be,
  input  logic [DATA_W-1:0]      bg_data,
  input  logic                   bg_en,
  input  logic [X_W-1:0]         vga_x,
  input  logic [Y_W-1:0]         vga_y,
  output logic [DATA_W-1:0]      vga_data,
  output logic                   vga_data_valid,
  output logic                   display_frame,
  output logic                   frame_swapped,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic [ADDR_W-1:0]      SRAM_ADDR,
  inout  wire  [DATA_W-1:0]      SRAM_DQ
);

  if (ADDR_W != 1 + Y_W + X_W) begin : g_bad_addr_w
    $error("sram_frame_arbiter: ADDR_W must equal 1+Y_W+X_W");
  end
  if (DATA_W != 16) begin : g_bad_data_w
    $error("sram_frame_arbiter: DATA_W must be 16");
  end
  if (N_WR < 1 || N_WR > 4) begin : g_bad_n_wr
    $error("sram_frame_arbiter: N_WR must be 1..4");
  end

  slot_e  slot, slot_nxt;
  phase_t phase, phase_nxt;
  logic   wr_arb;

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot  <= S_WR0;
      phase <= 1'b0;
    end else begin
      slot  <= slot_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    phase_nxt = ~phase;
    slot_nxt  = slot;
    if (phase) begin
      unique case (slot)
        S_WR0: slot_nxt = S_VGA;
        S_VGA: slot_nxt = S_WR1;
        S_WR1: slot_nxt = S_BG;
        S_BG:  slot_nxt = S_WR0;
      endcase
    end
    wr_arb = (slot == S_WR0 || slot == S_WR1) && !phase;
  end

  logic [N_WR-1:0] gnt;

  rr_arbiter #(.N(N_WR)) u_rr (
    .sram_clk (sram_clk),
    .reset_n  (reset_n),
    .req      (wr_valid),
    .advance  (wr_arb),
    .gnt      (gnt)
  );

  assign wr_ready = wr_arb ? gnt : '0;

  logic [X_W-1:0]    sel_x;
  logic [Y_W-1:0]    sel_y;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_be;

  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_data = '0;
    sel_be   = '0;
    for (int i = 0; i < N_WR; i++) begin
      if (gnt[i]) begin
        sel_x    = wr_x[i*X_W +: X_W];
        sel_y    = wr_y[i*Y_W +: Y_W];
        sel_data = wr_data[i*DATA_W +: DATA_W];
        sel_be   = wr_be[i*2 +: 2];
      end
    end
  end

  // Writes land in the hidden frame; VGA read and background clear use the
  // displayed one. The address is latched with the grant, so a swap can never
  // split a write.
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] vga_addr;
  assign wr_addr  = ADDR_W'(make_addr(~display_frame, 32'(sel_x), 32'(sel_y), X_W, Y_W));
  assign vga_addr = ADDR_W'(make_addr(display_frame, 32'(vga_x), 32'(vga_y), X_W, Y_W));

  // Frame tick: 2-FF synchroniser plus one stage for rising-edge detect.
  logic [2:0] fsync;
  logic       frame_rise;
  logic       swap_pending;
  logic       boundary;

  assign frame_rise = fsync[1] & ~fsync[2];
  assign boundary   = (slot == S_BG) && phase;

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      fsync         <= '0;
      swap_pending  <= 1'b0;
      display_frame <= 1'b0;
      frame_swapped <= 1'b0;
    end else begin
      fsync         <= {fsync[1:0], frame_clk};
      frame_swapped <= 1'b0;
      if (boundary && swap_pending) begin
        display_frame <= ~display_frame;
        frame_swapped <= 1'b1;
        // A tick seen on the boundary cycle belongs to the next rotation.
        swap_pending  <= frame_rise;
      end else if (frame_rise) begin
        swap_pending  <= 1'b1;
      end
    end
  end

  // SRAM side. ph0 edges set up the access, ph1 edges end the strobe but keep
  // ADDR/DQ for hold; DQ is released on the same edge that drops OE_N.
  logic [DATA_W-1:0] dq_out;
  logic              dq_oe;

  assign SRAM_DQ = dq_oe ? dq_out : {DATA_W{1'bz}};

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      SRAM_CE_N      <= 1'b0;
      SRAM_OE_N      <= 1'b1;
      SRAM_WE_N      <= 1'b1;
      SRAM_UB_N      <= 1'b1;
      SRAM_LB_N      <= 1'b1;
      SRAM_ADDR      <= '0;
      dq_out         <= '0;
      dq_oe          <= 1'b0;
      vga_data       <= '0;
      vga_data_valid <= 1'b0;
    end else begin
      SRAM_CE_N      <= 1'b0;
      vga_data_valid <= 1'b0;
      if (!phase) begin
        unique case (slot)
          S_WR0, S_WR1: begin
            if (|gnt) begin
              SRAM_ADDR <= wr_addr;
              dq_out    <= sel_data;
              dq_oe     <= 1'b1;
              SRAM_WE_N <= 1'b0;
              SRAM_UB_N <= ~sel_be[1];
              SRAM_LB_N <= ~sel_be[0];
            end else begin
              dq_oe     <= 1'b0;
            end
          end
          S_VGA: begin
            SRAM_ADDR <= vga_addr;
            dq_oe     <= 1'b0;
            SRAM_OE_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
          end
          S_BG: begin
            if (bg_en) begin
              SRAM_ADDR <= vga_addr;
              dq_out    <= bg_data;
              dq_oe     <= 1'b1;
              SRAM_WE_N <= 1'b0;
              SRAM_UB_N <= 1'b0;
              SRAM_LB_N <= 1'b0;
            end else begin
              dq_oe     <= 1'b0;
            end
          end
        endcase
      end else begin
        SRAM_WE_N <= 1'b1;
        SRAM_OE_N <= 1'b1;
        SRAM_UB_N <= 1'b1;
        SRAM_LB_N <= 1'b1;
        if (slot == S_VGA) begin
          vga_data       <= SRAM_DQ;
          vga_data_valid <= 1'b1;
        end
      end
    end
  end

endmodule
